switch_debouncer: RTL

- Consumes the synchronized slide-switch vector from the input synchronizer.
- Produces glitch-free debounced levels plus one-cycle rise/fall strobes per bit, for downstream mode/control logic on the DE10-Lite.
- Each bit runs an independent two-state FSM with a stability counter.
- A new level is accepted only after it has persisted for a programmable number of consecutive clock samples.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_bit.sv | 97 +++++++++
 rtl/switch_debouncer.sv | 46 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the slide-switch debouncer.
package debounce_pkg;

  // Per-bit debounce state: IDLE when the input agrees with the accepted
  // level, PEND while a differing level is being timed.
  typedef enum logic {
    DB_IDLE,
    DB_PEND
  } db_state_t;

  // 1 ms at 50 MHz for the board build; a short value keeps simulation fast.
  localparam int DEFAULT_STABLE_CYCLES = 50000;
  localparam int SIM_STABLE_CYCLES     = 4;

endpackage : debounce_pkg

// File: rtl/debounce_bit.sv
// Single-bit debouncer: a two-state FSM with a stability counter. A new level
// is accepted only after STABLE_CYCLES consecutive differing samples, and the
// accepted edge is announced with a one-cycle rise or fall pulse.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_commit
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic             w_differ;
  logic             w_commit;

  assign w_differ = i_sw ^ r_db;

  // Next-state and counter logic; w_commit flags the cycle a new level is accepted.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    unique case (r_state)
      DB_IDLE: begin
        if (w_differ) begin
          if (STABLE_CYCLES == 1) begin
            // One sample is already enough: accept without visiting PEND.
            w_commit = 1'b1;
          end else begin
            w_state_nxt = DB_PEND;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      DB_PEND: begin
        if (!w_differ) begin
          // Input bounced back to the accepted level: drop the count silently.
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = DB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, accepted level and edge pulses; pulses last one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DB_IDLE;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= r_db ^ w_commit;
      r_rise  <= w_commit & ~r_db;
      r_fall  <= w_commit & r_db;
    end
  end

  assign o_db     = r_db;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_commit = w_commit;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Debouncer for the synchronized slide-switch vector: one independent
// debounce_bit per switch plus a registered any-change strobe.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  logic [WIDTH-1:0] w_commit;
  logic             r_any_change;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .i_sw    (sw_in[gi]),
      .o_db    (sw_db[gi]),
      .o_rise  (sw_rise[gi]),
      .o_fall  (sw_fall[gi]),
      .o_commit(w_commit[gi])
    );
  end

  // Registered from the commit terms so it lines up with the per-bit pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any_change <= 1'b0;
    end else begin
      r_any_change <= |w_commit;
    end
  end

  assign any_change = r_any_change;

endmodule : switch_debouncer
